// File: rtl/usr_pkg.sv
// Shared types for the burst shift register: operation codes, FSM states
// and the shift-mode classifier.
package usr_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        ModeHold  = 3'b000,
        ModeShr   = 3'b001,
        ModeShl   = 3'b010,
        ModeLoad  = 3'b011,
        ModeRotr  = 3'b100,
        ModeRotl  = 3'b101,
        ModeAshr  = 3'b110,
        ModeClear = 3'b111
    } mode_e;

    typedef enum logic {
        StIdle,
        StBurst
    } state_e;

    function automatic logic is_shift_mode(mode_e m);
        return (m == ModeShr) || (m == ModeShl) || (m == ModeRotr) ||
               (m == ModeRotl) || (m == ModeAshr);
    endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next value of the register for a single operation step.
module usr_step
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             sl_in,
    input  logic             sr_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next
);

    always_comb begin
        q_next = q;
        unique case (mode)
            ModeHold:  q_next = q;
            ModeShr:   q_next = {sr_in, q[WIDTH-1:1]};
            ModeShl:   q_next = {q[WIDTH-2:0], sl_in};
            ModeLoad:  q_next = d;
            ModeRotr:  q_next = {q[0], q[WIDTH-1:1]};
            ModeRotl:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            ModeAshr:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            ModeClear: q_next = '0;
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/usr_burst_shifter.sv
// Universal shift register with multi-bit burst shifts and a busy/done handshake.
// Define USR_PARITY_EN to add the registered parity output q_par.
module usr_burst_shifter
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [AMT_W-1:0]  amt,
    input  logic              sl_in,
    input  logic              sr_in,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic              sout_msb,
    output logic              sout_lsb,
    output logic              busy,
    output logic              done
`ifdef USR_PARITY_EN
    ,
    output logic              q_par
`endif
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d, step_mode, cmd_mode;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d, step_q;
    logic             busy_q, busy_d, done_q, done_d;
    logic             cmd_shift;

    assign cmd_mode  = mode_e'(mode);
    assign cmd_shift = is_shift_mode(cmd_mode);

    // A shift command with zero amount still completes, but must not move q.
    always_comb begin
        step_mode = ModeHold;
        if (state_q == StBurst) begin
            step_mode = mode_q;
        end else if (start && !(cmd_shift && amt == '0)) begin
            step_mode = cmd_mode;
        end
    end

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (q_q),
        .mode   (step_mode),
        .sl_in  (sl_in),
        .sr_in  (sr_in),
        .d      (d),
        .q_next (step_q)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (ena) begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_d = cmd_mode;
                        q_d    = step_q;
                        if (cmd_shift && amt > AMT_W'(1)) begin
                            state_d = StBurst;
                            cnt_d   = amt - AMT_W'(1);
                            busy_d  = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StBurst: begin
                    q_d   = step_q;
                    cnt_d = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            mode_q  <= ModeHold;
            cnt_q   <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef USR_PARITY_EN
    logic par_q, par_d;

    // Parity of the next value, so it lines up with q in the same cycle.
    assign par_d = ^q_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign q_par = par_q;
`endif

    assign q        = q_q;
    assign sout_msb = q_q[WIDTH-1];
    assign sout_lsb = q_q[0];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: doc/usr_burst_shifter.md
Name: usr_burst_shifter

Overview:
- Parametrised successor to the team's 4-bit universal shift register.
- Adds configurable width, rotate and arithmetic modes, and multi-bit "burst" shifts: a single start command shifts the register by a programmable amount, one bit per enabled cycle.
- A busy/done handshake tells the controller when the burst has finished.
- Sits behind the Tiny Tapeout wrapper or any controller that needs serial/parallel data conversion.

Parameters:
- WIDTH, 8, register width in bits (≥2).
- AMT_W, 4, width of the shift-amount field; max burst = 2^AMT_W−1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- ena  input  1  global enable; when 0 the block freezes (state, counter and q held).
- start  input  1  command strobe; sampled only in IDLE with ena=1.
- mode  input  3  operation code, latched at start.
- amt  input  AMT_W  shift count, latched at start.
- sl_in  input  1  serial input entering the LSB on shift-left.
- sr_in  input  1  serial input entering the MSB on shift-right.
- d  input  WIDTH  parallel load data.
- q  output  WIDTH  register state.
- sout_msb  output  1  equals q[WIDTH-1].
- sout_lsb  output  1  equals q[0].
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (rst_n=0 at a clk edge): q=0, busy=0, done=0, state=IDLE, counter=0. Reset dominates ena and start, and aborts any burst in progress without a done pulse.
- Mode codes:
  - 000 HOLD
  - 001 SHR: q <= {sr_in, q[W-1:1]}
  - 010 SHL: q <= {q[W-2:0], sl_in}
  - 011 LOAD: q <= d
  - 100 ROTR: q <= {q[0], q[W-1:1]}
  - 101 ROTL: q <= {q[W-2:0], q[W-1]}
  - 110 ASHR: q <= {q[W-1], q[W-1:1]}
  - 111 CLEAR: q <= 0
- States: IDLE and BURST.
- IDLE with ena=1 and start=1:
  - Single-cycle modes (HOLD, LOAD, CLEAR): q updates at that edge; done=1 on the following cycle; stay in IDLE.
  - Shift modes (001, 010, 100, 101, 110) with amt=0: q unchanged; done=1 next cycle; stay in IDLE.
  - Shift modes with amt=N>0: the first shift happens at the start edge. If N=1, behave like the single-cycle case. If N>1, go to BURST with counter=N−1 and busy=1.
- BURST with ena=1: one shift per edge, counter decrements. On the edge where counter goes 1→0, return to IDLE, busy=0, done=1 for exactly one cycle.
- Total: an N-bit burst occupies N enabled edges; done asserts the cycle after the last shift.
- sl_in and sr_in are sampled live at every shift edge, not latched at start.
- mode, amt and d are latched at start; later changes have no effect until the next command.
- start during BURST is ignored. start together with ena=0 is ignored.
- ena=0 mid-burst: pause. q, counter and busy are held. done is held low and is still issued after the remaining shifts once ena returns.
- done and busy are never high in the same cycle.
- Back-to-back commands: start may be asserted in the cycle done is high (state is IDLE); the new command is accepted.
- sout_msb and sout_lsb are combinational from q.

Optional Feature:
- Macro USR_PARITY_EN.
- When defined: extra output port q_par (1 bit), the registered XOR-reduce of the next q, so q_par always equals ^q in the same cycle. Reset value 0.
- When undefined: the port is absent and no parity logic is generated.

Decomposition:
- Package usr_pkg holds:
  - mode_e: 3-bit enum with the codes above.
  - state_e: IDLE, BURST.
  - localparam MODE_W=3.
  - function is_shift_mode(mode_e).
- Sub-module usr_step: purely combinational next-value for one step, with inputs q, mode, sl_in, sr_in, d and output q_next. The top holds the FSM, counter, latches and outputs.

Test Plan (WIDTH=8, AMT_W=4):
1. Reset then LOAD: rst_n=0 for 2 cycles, then start, mode=011, d=0xA5 → q=0xA5 at the start edge; done pulses one cycle later; busy stays 0.
2. Burst SHL: q=0x01, start, mode=010, amt=3, sl_in=1 → q goes 0x03, 0x07, 0x0F over 3 edges; busy high for 2 cycles; done for 1 cycle after the last shift.
3. ROTR wrap and ASHR: q=0x81, ROTR amt=1 → q=0xC0. Then ASHR amt=2 → q goes 0xE0, then 0xF0.
4. ena pause: SHR amt=4 on q=0xF0 with sr_in=0; drop ena for 3 cycles after the 2nd shift → q holds 0x3C and busy stays 1. Resume → q becomes 0x0F, then done.
5. Edge commands: amt=0 SHL → q unchanged, done pulses. start during BURST → ignored, burst length unchanged. rst_n=0 mid-burst → q=0, busy=0, no done.
6. With USR_PARITY_EN defined: LOAD 0x07 → q_par=1. Then SHL with sl_in=0 → q=0x0E, q_par=1. Then LOAD 0x03 → q_par=0.
